// File: rtl/alu_issue_stage.sv
// Registered issue stage between decode and a combinational ALU.
// Two-entry buffer (MAIN drives the ALU, SKID absorbs one extra accept) so that
// in_ready can come straight from a flop. Operands are forwarded at capture
// and refreshed from the writeback port while held.
module alu_issue_stage #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned REG_IDX_W     = 5,
  parameter int unsigned ALU_OP_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  // Decode side
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALU_OP_LENGTH-1:0] in_alu_op,
  input  logic [REG_IDX_W-1:0]     in_rs1_idx,
  input  logic [REG_IDX_W-1:0]     in_rs2_idx,
  input  logic [XLEN-1:0]          in_rs1_val,
  input  logic [XLEN-1:0]          in_rs2_val,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_imm,
  input  logic                     in_sel_left,
  input  logic                     in_sel_right,
  input  logic [REG_IDX_W-1:0]     in_rd,
  // ALU side
  output logic [ALU_OP_LENGTH-1:0] alu_opcode,
  output logic [XLEN-1:0]          alu_left,
  output logic [XLEN-1:0]          alu_right,
  input  logic [XLEN-1:0]          alu_result,
  // Downstream handshake
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_IDX_W-1:0]     out_rd,
  // Writeback port
  input  logic                     wb_valid,
  input  logic [REG_IDX_W-1:0]     wb_rd,
  input  logic [XLEN-1:0]          wb_data
);

  typedef struct packed {
    logic [ALU_OP_LENGTH-1:0] op;
    logic [XLEN-1:0]          left;
    logic [XLEN-1:0]          right;
    logic [REG_IDX_W-1:0]     rd;
    logic [REG_IDX_W-1:0]     rs1;
    logic [REG_IDX_W-1:0]     rs2;
    logic                     sel_left;
    logic                     sel_right;
  } entry_t;

  // Occupancy of the MAIN/SKID pair; MAIN is always the older entry.
  typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

  occ_e   state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t main_snoop, skid_snoop, in_entry;
  logic   in_ready_q;
  logic   main_valid, accept, fire;

  // Writeback hit on a source index; x0 never matches.
  function automatic logic wb_hit(input logic                 v,
                                  input logic [REG_IDX_W-1:0] wrd,
                                  input logic [REG_IDX_W-1:0] idx);
    return v && (wrd == idx) && (idx != '0);
  endfunction

  // Refresh register-sourced operands of a held entry from writeback.
  function automatic entry_t snoop(input entry_t                 e,
                                   input logic                   v,
                                   input logic [REG_IDX_W-1:0]   wrd,
                                   input logic [XLEN-1:0]        wdata);
    entry_t r;
    r = e;
    if (!e.sel_left && wb_hit(v, wrd, e.rs1)) r.left = wdata;
    if (!e.sel_right && wb_hit(v, wrd, e.rs2)) r.right = wdata;
    return r;
  endfunction

  assign main_valid = (state_q != StEmpty);
  assign accept     = in_valid && in_ready_q;
  assign fire       = main_valid && out_ready;

  // Build the incoming entry with EX-over-WB forwarding priority.
  always_comb begin
    logic [XLEN-1:0] fwd1, fwd2;
    fwd1 = in_rs1_val;
    fwd2 = in_rs2_val;
    if (main_valid && (main_q.rd == in_rs1_idx) && (in_rs1_idx != '0)) begin
      fwd1 = alu_result;
    end else if (wb_hit(wb_valid, wb_rd, in_rs1_idx)) begin
      fwd1 = wb_data;
    end
    if (main_valid && (main_q.rd == in_rs2_idx) && (in_rs2_idx != '0)) begin
      fwd2 = alu_result;
    end else if (wb_hit(wb_valid, wb_rd, in_rs2_idx)) begin
      fwd2 = wb_data;
    end
    in_entry.op        = in_alu_op;
    in_entry.left      = in_sel_left ? in_pc : fwd1;
    in_entry.right     = in_sel_right ? in_imm : fwd2;
    in_entry.rd        = in_rd;
    in_entry.rs1       = in_rs1_idx;
    in_entry.rs2       = in_rs2_idx;
    in_entry.sel_left  = in_sel_left;
    in_entry.sel_right = in_sel_right;
  end

  // Snooped views of the held entries for this cycle.
  always_comb begin
    main_snoop = snoop(main_q, wb_valid, wb_rd, wb_data);
    skid_snoop = snoop(skid_q, wb_valid, wb_rd, wb_data);
  end

  // Occupancy next-state and entry movement; flush overrides everything.
  always_comb begin
    state_d = state_q;
    main_d  = main_snoop;
    skid_d  = skid_snoop;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && fire) begin
          main_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = StTwo;
        end else if (fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (fire) begin
          main_d  = skid_snoop;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // State and entry registers; in_ready follows the next occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != StTwo);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid;
  assign alu_opcode = main_q.op;
  assign alu_left   = main_q.left;
  assign alu_right  = main_q.right;
  assign out_rd     = main_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed + random bench for alu_issue_stage against a queue-based model.
module tb_alu_issue_stage;

  localparam int XL = 32;
  localparam int RW = 5;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_alu_op;
  logic [RW-1:0] in_rs1_idx, in_rs2_idx, in_rd;
  logic [XL-1:0] in_rs1_val, in_rs2_val, in_pc, in_imm;
  logic          in_sel_left, in_sel_right;
  logic [OW-1:0] alu_opcode;
  logic [XL-1:0] alu_left, alu_right, alu_result;
  logic          out_valid, out_ready;
  logic [RW-1:0] out_rd;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [XL-1:0] wb_data;

  int total = 0;
  int bad   = 0;

  localparam logic [OW-1:0] OpAdd = 4'd0;
  localparam logic [OW-1:0] OpSub = 4'd1;
  localparam logic [OW-1:0] OpAnd = 4'd2;

  always #5 clk = ~clk;

  // Behavioural ALU feeding the DUT's alu_result.
  function automatic logic [XL-1:0] alu_f(input logic [OW-1:0] op,
                                          input logic [XL-1:0] a,
                                          input logic [XL-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_left, alu_right);

  alu_issue_stage #(.XLEN(XL), .REG_IDX_W(RW), .ALU_OP_LENGTH(OW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_sel_left(in_sel_left), .in_sel_right(in_sel_right), .in_rd(in_rd),
    .alu_opcode(alu_opcode), .alu_left(alu_left), .alu_right(alu_right),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  // Reference model: ordered list of held instructions, oldest first.
  typedef struct {
    logic [OW-1:0] op;
    logic [XL-1:0] l;
    logic [XL-1:0] r;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          sl;
    logic          sr;
  } ment_t;

  ment_t mq[$];
  bit    m_ready;

  task automatic chk(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XL-1:0] fwd_m(input logic [RW-1:0] idx, input logic [XL-1:0] val);
    if (idx != 0 && mq.size() > 0 && mq[0].rd == idx) return alu_f(mq[0].op, mq[0].l, mq[0].r);
    if (idx != 0 && wb_valid && wb_rd == idx) return wb_data;
    return val;
  endfunction

  // One clock: predict from pre-edge inputs, clock, then compare.
  task automatic cycle();
    ment_t ne;
    bit    acc, fir;
    acc = in_valid && m_ready;
    fir = (mq.size() > 0) && out_ready;
    ne.op  = in_alu_op;
    ne.l   = in_sel_left ? in_pc : fwd_m(in_rs1_idx, in_rs1_val);
    ne.r   = in_sel_right ? in_imm : fwd_m(in_rs2_idx, in_rs2_val);
    ne.rd  = in_rd;
    ne.rs1 = in_rs1_idx;
    ne.rs2 = in_rs2_idx;
    ne.sl  = in_sel_left;
    ne.sr  = in_sel_right;
    foreach (mq[i]) begin
      if (!mq[i].sl && wb_valid && mq[i].rs1 != 0 && wb_rd == mq[i].rs1) mq[i].l = wb_data;
      if (!mq[i].sr && wb_valid && mq[i].rs2 != 0 && wb_rd == mq[i].rs2) mq[i].r = wb_data;
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (fir) void'(mq.pop_front());
      if (acc) mq.push_back(ne);
    end
    m_ready = (mq.size() < 2);
    @(posedge clk);
    #1;
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("alu_opcode", alu_opcode, mq[0].op);
      chk("alu_left", alu_left, mq[0].l);
      chk("alu_right", alu_right, mq[0].r);
      chk("out_rd", out_rd, mq[0].rd);
    end
  endtask

  task automatic drive(input logic v, input logic [OW-1:0] op,
                       input logic [RW-1:0] rs1, input logic [XL-1:0] v1,
                       input logic [RW-1:0] rs2, input logic [XL-1:0] v2,
                       input logic sl, input logic sr, input logic [XL-1:0] pc,
                       input logic [XL-1:0] imm, input logic [RW-1:0] rd);
    in_valid = v; in_alu_op = op;
    in_rs1_idx = rs1; in_rs1_val = v1; in_rs2_idx = rs2; in_rs2_val = v2;
    in_sel_left = sl; in_sel_right = sr; in_pc = pc; in_imm = imm; in_rd = rd;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    idle();
    mq.delete(); m_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_left", alu_left, 0);
    chk("rst_right", alu_right, 0);
    chk("rst_out_rd", out_rd, 0);

    // Single ADD 4 + 3
    drive(1'b1, OpAdd, 5'd1, 32'd4, 5'd2, 32'd3, 1'b0, 1'b0, '0, '0, 5'd6);
    cycle();
    chk("add_result", alu_result, 32'd7);
    idle(); out_ready = 1'b1;
    cycle();

    // Back-pressure: SUB then AND into SKID
    out_ready = 1'b0;
    drive(1'b1, OpSub, 5'd1, 32'd7, 5'd2, 32'd3, 1'b0, 1'b0, '0, '0, 5'd7);
    cycle();
    drive(1'b1, OpAnd, 5'd1, 32'hC, 5'd2, 32'hA, 1'b0, 1'b0, '0, '0, 5'd8);
    cycle();
    chk("bp_in_ready_low", in_ready, 0);
    idle();
    cycle();
    out_ready = 1'b1;
    chk("sub_result", alu_result, 32'd4);
    cycle();
    chk("bp_in_ready_high", in_ready, 1);
    chk("and_result", alu_result, 32'h8);
    cycle();

    // EX forwarding from MAIN rd=5, then x0 not forwarded
    out_ready = 1'b0;
    drive(1'b1, OpAdd, 5'd1, 32'd3, 5'd2, 32'd4, 1'b0, 1'b0, '0, '0, 5'd5);
    cycle();
    out_ready = 1'b1;
    drive(1'b1, OpAdd, 5'd5, 32'd0, 5'd0, 32'd1, 1'b0, 1'b0, '0, '0, 5'd9);
    cycle();
    chk("ex_fwd_left", alu_left, 32'd7);
    drive(1'b1, OpAdd, 5'd1, 32'd2, 5'd2, 32'd5, 1'b0, 1'b0, '0, '0, 5'd0);
    cycle();
    drive(1'b1, OpAdd, 5'd0, 32'd11, 5'd2, 32'd1, 1'b0, 1'b0, '0, '0, 5'd3);
    cycle();
    chk("x0_no_fwd", alu_left, 32'd11);
    idle();
    cycle();

    // WB snoop on held entries; immediate operand untouched
    out_ready = 1'b0;
    drive(1'b1, OpAdd, 5'd1, 32'd1, 5'd3, 32'd1, 1'b0, 1'b0, '0, '0, 5'd10);
    cycle();
    drive(1'b1, OpAdd, 5'd0, 32'd1, 5'd3, 32'd1, 1'b0, 1'b1, '0, 32'h55, 5'd11);
    cycle();
    idle(); wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hA;
    cycle();
    chk("snoop_right", alu_right, 32'hA);
    wb_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("imm_unsnooped", alu_right, 32'h55);
    cycle();

    // Flush with SKID full and in_valid high
    out_ready = 1'b0;
    drive(1'b1, OpAdd, 5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 1'b0, '0, '0, 5'd12);
    cycle();
    drive(1'b1, OpSub, 5'd1, 32'd5, 5'd2, 32'd2, 1'b0, 1'b0, '0, '0, 5'd13);
    cycle();
    flush = 1'b1;
    drive(1'b1, OpAnd, 5'd1, 32'd5, 5'd2, 32'd2, 1'b0, 1'b0, '0, '0, 5'd14);
    cycle();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    flush = 1'b0; idle(); out_ready = 1'b1;
    cycle();
    cycle();

    // EX beats WB on the same source
    out_ready = 1'b0;
    drive(1'b1, OpAdd, 5'd1, 32'd4, 5'd2, 32'd5, 1'b0, 1'b0, '0, '0, 5'd4);
    cycle();
    out_ready = 1'b1; wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'd5;
    drive(1'b1, OpAdd, 5'd4, 32'd0, 5'd0, 32'd1, 1'b0, 1'b0, '0, '0, 5'd1);
    cycle();
    chk("prio_left", alu_left, 32'd9);
    wb_valid = 1'b0; idle();
    cycle();

    // Random traffic with a small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 6)),
            5'($urandom_range(0, 3)), $urandom(), 5'($urandom_range(0, 3)), $urandom(),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            $urandom(), $urandom(), 5'($urandom_range(0, 3)));
      out_ready = 1'($urandom_range(0, 2) != 0);
      wb_valid  = 1'($urandom_range(0, 1));
      wb_rd     = 5'($urandom_range(0, 3));
      wb_data   = $urandom();
      flush     = 1'($urandom_range(0, 40) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
